// File: rtl/sync_byte_fifo_pkg.sv
// Purpose : shared constants and helpers for the sync_byte_fifo slice.
//           Address-width rule and the power-of-two depth test used at elaboration.
// Ports   : none (package)
package sync_byte_fifo_pkg;

  // Pointer width for a given depth. A depth of 1 still needs one pointer bit.
  function automatic int unsigned fifo_addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Pointers wrap for free only when the depth is a power of two.
  function automatic bit fifo_is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_byte_fifo_mem.sv
// Purpose : DEPTH x DATA_WIDTH register array for the FIFO.
// Ports   : clk            - rising-edge clock
//           we/waddr/wdata - synchronous write port
//           raddr/rdata    - asynchronous read port
// The array is deliberately not reset.
module sync_byte_fifo_mem
  import sync_byte_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_byte_fifo.sv
// Purpose : synchronous first-word-fall-through FIFO between the USB3300
//           receive path and the packet parser. Holds the pointers, level
//           counter, status decode and sticky overflow/underflow flags.
// Ports   : clk, rst_n (sync, active low)
//           wr_en/wr_data  - push request and word
//           rd_en/rd_data  - pop request and head word (0 when empty)
//           empty/full/almost_full/level - occupancy status (from level reg)
//           overflow/underflow - sticky error flags, cleared by clr_err
module sync_byte_fifo
  import sync_byte_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       wr_en,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  input  logic                                       rd_en,
  output logic [DATA_WIDTH-1:0]                      rd_data,
  output logic                                       empty,
  output logic                                       full,
  output logic                                       almost_full,
  output logic [fifo_addr_width(DEPTH):0]            level,
  output logic                                       overflow,
  output logic                                       underflow,
  input  logic                                       clr_err
);

  localparam int AW = fifo_addr_width(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [AW:0] C_AFULL = (AW + 1)'(AFULL_LEVEL);

  if (!fifo_is_pow2(DEPTH)) begin : g_depth_check
    $error("sync_byte_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_afull_check
    $error("sync_byte_fifo: AFULL_LEVEL must be within 1..DEPTH");
  end

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_level;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_head;

  // Status comes only from the level register, never from wr_en/rd_en.
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == C_DEPTH);

  // A pop while full frees the head, so the push in that cycle is accepted.
  assign w_push_ok = wr_en & (~w_full | rd_en);
  assign w_pop_ok  = rd_en & ~w_empty;

  // Reset wins over the write port too, so the word presented during reset is dropped.
  assign w_mem_we = w_push_ok & rst_n;

  sync_byte_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (r_wr_ptr),
    .wdata (wr_data),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      // Set beats clear when an error lands in the same cycle as clr_err.
      if (wr_en & w_full & ~rd_en) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (rd_en & w_empty) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign rd_data     = w_empty ? '0 : w_head;
  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (r_level >= C_AFULL);
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_sync_byte_fifo.sv
module tb_sync_byte_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [3:0] level;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int n_tests;
  int n_fail;

  sync_byte_fifo #(
    .DATA_WIDTH  (8),
    .DEPTH       (8),
    .AFULL_LEVEL (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
    step();
    idle();
  endtask

  // Check the head word, then pop it.
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1; wr_en = 1'b0;
    step();
    idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
    step();
    step();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_afull", {31'd0, almost_full}, 32'd0);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_unf", {31'd0, underflow}, 32'd0);
    idle();

    // 1: fill and drain in order
    for (int i = 0; i < 8; i++) begin
      push(8'h11 + 8'(i));
      chk("t1_level", {28'd0, level}, 32'(i + 1));
      chk("t1_afull", {31'd0, almost_full}, {31'd0, (i + 1) >= 6});
      chk("t1_full", {31'd0, full}, {31'd0, i == 7});
      chk("t1_head", {24'd0, rd_data}, 32'h11);
    end
    for (int i = 0; i < 8; i++) begin
      pop_chk("t1_pop_data", 8'h11 + 8'(i));
      chk("t1_pop_level", {28'd0, level}, 32'(7 - i));
    end
    chk("t1_empty", {31'd0, empty}, 32'd1);
    chk("t1_rd_zero", {24'd0, rd_data}, 32'd0);

    // 2: overflow on full, then clear
    for (int i = 0; i < 8; i++) push(8'h21 + 8'(i));
    push(8'hAA);
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    chk("t2_level", {28'd0, level}, 32'd8);
    chk("t2_head", {24'd0, rd_data}, 32'h21);
    clr_err = 1'b1;
    step();
    idle();
    chk("t2_ovf_clr", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) pop_chk("t2_contents", 8'h21 + 8'(i));
    chk("t2_empty", {31'd0, empty}, 32'd1);

    // 3: pop+push while empty
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5C;
    step();
    idle();
    chk("t3_unf", {31'd0, underflow}, 32'd1);
    chk("t3_level", {28'd0, level}, 32'd1);
    chk("t3_data", {24'd0, rd_data}, 32'h5C);
    clr_err = 1'b1;
    step();
    idle();
    chk("t3_unf_clr", {31'd0, underflow}, 32'd0);
    pop_chk("t3_pop", 8'h5C);
    chk("t3_empty", {31'd0, empty}, 32'd1);

    // 4: push+pop while full
    for (int i = 0; i < 8; i++) push(8'h31 + 8'(i));
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
    step();
    idle();
    chk("t4_level", {28'd0, level}, 32'd8);
    chk("t4_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 7; i++) pop_chk("t4_order", 8'h32 + 8'(i));
    pop_chk("t4_last", 8'h99);
    chk("t4_empty", {31'd0, empty}, 32'd1);

    // 5: steady-state push+pop at level 3, pointers wrap
    push(8'h40); push(8'h41); push(8'h42);
    for (int k = 0; k < 20; k++) begin
      chk("t5_head", {24'd0, rd_data}, 32'h40 + 32'(k));
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h43 + 8'(k);
      step();
      idle();
      chk("t5_level", {28'd0, level}, 32'd3);
    end
    pop_chk("t5_drain0", 8'h54);
    pop_chk("t5_drain1", 8'h55);
    pop_chk("t5_drain2", 8'h56);
    chk("t5_empty", {31'd0, empty}, 32'd1);

    // 6: reset mid-operation with a pending error and a push request
    rd_en = 1'b1;
    step();
    idle();
    chk("t6_unf_set", {31'd0, underflow}, 32'd1);
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    chk("t6_level5", {28'd0, level}, 32'd5);
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    step();
    idle();
    chk("t6_level", {28'd0, level}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_ovf", {31'd0, overflow}, 32'd0);
    chk("t6_unf", {31'd0, underflow}, 32'd0);
    chk("t6_rd_zero", {24'd0, rd_data}, 32'd0);
    step();
    chk("t6_not_stored", {28'd0, level}, 32'd0);
    push(8'h77);
    chk("t6_after_head", {24'd0, rd_data}, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
